// File: rtl/cal_serial_ctrl.sv
// Bit-serial sequencer for one external 1-bit cal cell: shifts operands LSB-first,
// recirculates carry and assembles the result. Optional overflow flag: CAL_SERIAL_OVF_EN.
module cal_serial_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_l,
  input  logic [1:0]       op_s,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             cal_a,
  output logic             cal_b,
  output logic             cal_l,
  output logic             cal_c_in,
  output logic [1:0]       cal_s,
  input  logic             cal_out,
  input  logic             cal_c_out
`ifdef CAL_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               l_q, l_d;
  logic [1:0]         s_q, s_d;
  logic               carry_q, carry_d;
  logic               carry_out_q, carry_out_d;
  logic               last_bit;
`ifdef CAL_SERIAL_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // NOTE: every target gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    l_d         = l_q;
    s_d         = s_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
`ifdef CAL_SERIAL_OVF_EN
    ovf_d       = ovf_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = op_a;
          b_sh_d  = op_b;
          l_d     = op_l;
          s_d     = op_s;
          carry_d = op_l ? 1'b0 : cin0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef CAL_SERIAL_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end

      S_RUN: begin
        result_d = {cal_out, result_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = l_q ? 1'b0 : cal_c_out;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d     = S_DONE;
          carry_out_d = l_q ? 1'b0 : cal_c_out;
`ifdef CAL_SERIAL_OVF_EN
          // Carry into the MSB is the carry fed to the cell on the last bit.
          ovf_d       = l_q ? 1'b0 : (carry_q ^ cal_c_out);
`endif
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      l_q         <= 1'b0;
      s_q         <= 2'b00;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
`ifdef CAL_SERIAL_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      l_q         <= l_d;
      s_q         <= s_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
`ifdef CAL_SERIAL_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Cell drive comes straight from registers and is gated to zero outside RUN.
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign cal_a     = busy & a_sh_q[0];
  assign cal_b     = busy & b_sh_q[0];
  assign cal_l     = busy & l_q;
  assign cal_c_in  = busy & carry_q;
  assign cal_s     = busy ? s_q : 2'b00;
`ifdef CAL_SERIAL_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cal_serial_ctrl.sv
// Self-checking bench for cal_serial_ctrl: behavioural cal cell, cycle-level
// acceptance model and a scoreboard queue of expected results.
module tb_cal_serial_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op_l = 1'b0;
  logic [1:0]   op_s = 2'b00;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin0 = 1'b0;
  logic         busy, done, carry_out;
  logic [W-1:0] result;
  logic         cal_a, cal_b, cal_l, cal_c_in;
  logic [1:0]   cal_s;
  logic         cal_out, cal_c_out;
`ifdef CAL_SERIAL_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  exp_t exp_q[$];
  int   cnt_m = 0;
  logic cur_l = 1'b0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_times[$];

  cal_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op_l(op_l), .op_s(op_s),
    .op_a(op_a), .op_b(op_b), .cin0(cin0), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out), .cal_a(cal_a), .cal_b(cal_b),
    .cal_l(cal_l), .cal_c_in(cal_c_in), .cal_s(cal_s), .cal_out(cal_out),
    .cal_c_out(cal_c_out)
`ifdef CAL_SERIAL_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural cal cell; its carry output stays live in logic mode on purpose.
  always_comb begin
    cal_c_out = (cal_a & cal_b) | (cal_a & cal_c_in) | (cal_b & cal_c_in);
    if (cal_l) begin
      case (cal_s)
        2'b00:   cal_out = cal_a & cal_b;
        2'b01:   cal_out = cal_a | cal_b;
        2'b10:   cal_out = cal_a ^ cal_b;
        default: cal_out = ~cal_a;
      endcase
    end else begin
      cal_out = cal_a ^ cal_b ^ cal_c_in;
    end
  end

  function automatic exp_t calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic l, input logic [1:0] s, input logic cin);
    exp_t e;
    logic [W:0] sum;
    if (!l) begin
      sum   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.res = sum[W-1:0];
      e.c   = sum[W];
      e.v   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
    end else begin
      case (s)
        2'b00:   e.res = a & b;
        2'b01:   e.res = a | b;
        2'b10:   e.res = a ^ b;
        default: e.res = ~a;
      endcase
      e.c = 1'b0;
      e.v = 1'b0;
    end
    return e;
  endfunction

  // Acceptance model: countdown of W+2 cycles per accepted operation.
  always @(posedge clk) begin
    if (reset) begin
      cnt_m <= 0;
      exp_q.delete();
    end else if (cnt_m == 0) begin
      if (start) begin
        exp_q.push_back(calc(op_a, op_b, op_l, op_s, cin0));
        cnt_m <= W + 1;
        cur_l <= op_l;
      end
    end else begin
      cnt_m <= cnt_m - 1;
    end
  end

  // Per-cycle monitor on the falling edge.
  always @(negedge clk) begin
    logic exp_busy, exp_done;
    exp_t e;
    cyc = cyc + 1;
    exp_busy = (cnt_m >= 2);
    exp_done = (cnt_m == 1);
    checks++;
    if (busy !== exp_busy || done !== exp_done) begin
      errors++;
      $display("FAIL handshake cyc=%0d: busy=%b done=%b, expected busy=%b done=%b",
               cyc, busy, done, exp_busy, exp_done);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_times.push_back(cyc);
    end
    if (exp_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty cyc=%0d: result=%b with no expected entry", cyc, result);
      end else begin
        e = exp_q.pop_front();
        if (result !== e.res || carry_out !== e.c) begin
          errors++;
          $display("FAIL result cyc=%0d: result=%b carry_out=%b, expected %b %b",
                   cyc, result, carry_out, e.res, e.c);
        end
`ifdef CAL_SERIAL_OVF_EN
        checks++;
        if (ovf !== e.v) begin
          errors++;
          $display("FAIL ovf cyc=%0d: ovf=%b, expected %b", cyc, ovf, e.v);
        end
`endif
      end
    end
    if (!exp_busy) begin
      checks++;
      if ({cal_a, cal_b, cal_l, cal_c_in, cal_s} !== 6'b0) begin
        errors++;
        $display("FAIL cal_idle cyc=%0d: cal bus=%b, expected 000000",
                 cyc, {cal_a, cal_b, cal_l, cal_c_in, cal_s});
      end
    end else if (cur_l) begin
      checks++;
      if (cal_c_in !== 1'b0) begin
        errors++;
        $display("FAIL logic_cin cyc=%0d: cal_c_in=%b, expected 0", cyc, cal_c_in);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cnt_m != 0 && n < 200) begin
      tick();
      n++;
    end
    if (cnt_m != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: model busy after %0d cycles, expected idle", n);
    end
  endtask

  // Pulses start for one cycle; returns in the first RUN cycle.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic l, input logic [1:0] s, input logic cin);
    op_a = a; op_b = b; op_l = l; op_s = s; cin0 = cin;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, done, result, carry_out, cal_a, cal_b, cal_l, cal_c_in, cal_s} !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b result=%b carry_out=%b cal=%b, expected all 0",
               busy, done, result, carry_out, {cal_a, cal_b, cal_l, cal_c_in, cal_s});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_arith();
    int n = 0;
    start_op(4'b0101, 4'b0011, 1'b0, 2'b00, 1'b0);
    while (busy === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    checks++;
    if (n != W || done !== 1'b1) begin
      errors++;
      $display("FAIL latency: busy cycles=%0d done=%b, expected %0d and 1", n, done, W);
    end
    wait_idle();
    start_op(4'b1111, 4'b0001, 1'b0, 2'b00, 1'b0);
    wait_idle();
    start_op(4'b0000, 4'b0000, 1'b0, 2'b00, 1'b1);
    wait_idle();
    start_op(4'b0111, 4'b1001, 1'b0, 2'b00, 1'b1);
    wait_idle();
  endtask

  task automatic test_logic();
    for (int s = 0; s < 4; s++) begin
      start_op(4'b1100, 4'b1010, 1'b1, 2'(s), 1'b1);
      wait_idle();
    end
  endtask

  task automatic test_start_in_run();
    int d0 = done_cnt;
    start_op(4'b0110, 4'b0101, 1'b0, 2'b00, 1'b0);
    tick();
    op_a = 4'b1111; op_b = 4'b1111; op_l = 1'b1; op_s = 2'b11; start = 1'b1;
    tick();
    op_a = 4'b0001; op_b = 4'b1000; op_l = 1'b0; cin0 = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
    repeat (4) tick();
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL start_in_run: done pulses=%0d, expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_run();
    int d0;
    start_op(4'b1111, 4'b1111, 1'b0, 2'b00, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, done, result, carry_out, cal_a, cal_b, cal_l, cal_c_in, cal_s} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b result=%b carry_out=%b cal=%b, expected all 0",
               busy, done, result, carry_out, {cal_a, cal_b, cal_l, cal_c_in, cal_s});
    end
    d0 = done_cnt;
    repeat (W + 4) tick();
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL reset_no_done: done pulses=%0d, expected 0", done_cnt - d0);
    end
    // reset and start in the same cycle: reset wins.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_vs_start: busy=%b, expected 0", busy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    int t0 = done_times.size();
    start = 1'b1;
    for (int i = 0; i < 3 * (W + 2); i++) begin
      op_a = W'($urandom);
      op_b = W'($urandom);
      op_l = 1'($urandom);
      op_s = 2'($urandom);
      cin0 = 1'($urandom);
      tick();
    end
    start = 1'b0;
    wait_idle();
    repeat (2) tick();
    checks++;
    if (done_cnt - d0 != 3) begin
      errors++;
      $display("FAIL b2b_count: done pulses=%0d, expected 3", done_cnt - d0);
    end
    for (int i = t0 + 1; i < done_times.size(); i++) begin
      checks++;
      if (done_times[i] - done_times[i-1] != W + 2) begin
        errors++;
        $display("FAIL b2b_spacing: %0d cycles, expected %0d",
                 done_times[i] - done_times[i-1], W + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_start_in_run();
    test_reset_mid_run();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cal_serial_ctrl.md
Name: cal_serial_ctrl

Overview:
Bit-serial sequencer that drives one external 1-bit cal cell (combinational full adder / logic unit) and collects its responses.
- Accepts a WIDTH-bit operation, then feeds the operand bits LSB-first to the cell, one bit per clock.
- Recirculates the cell's carry into its carry input between bits.
- Assembles the WIDTH-bit result and final carry, then pulses done.
- Sits between the datapath control and a cal instance; it is the response side of the cal interface.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 2..32

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op_l  input  1  0 = arithmetic (full add), 1 = logic
op_s  input  2  logic select: 00 AND, 01 OR, 10 XOR, 11 NOT A; ignored when op_l=0
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
cin0  input  1  initial carry-in for arithmetic mode
busy  output  1  high while an operation is in progress (RUN)
done  output  1  one-cycle pulse when result and carry_out become valid
result  output  WIDTH  assembled result; holds its value until the next accepted start
carry_out  output  1  final carry (arithmetic mode); 0 in logic mode
cal_a  output  1  to cell input a
cal_b  output  1  to cell input b
cal_l  output  1  to cell input l
cal_c_in  output  1  to cell input c_in
cal_s  output  2  to cell input s
cal_out  input  1  from cell output out
cal_c_out  input  1  from cell output c_out

Behaviour:
- States: IDLE, RUN, DONE. Reset forces IDLE from any state.
- Reset values: busy=0, done=0, result=0, carry_out=0, cal_a=0, cal_b=0, cal_l=0, cal_c_in=0, cal_s=00. Internal shift registers, bit counter and carry register are all cleared.
- IDLE with start=1:
  - Latch op_a and op_b into shift registers a_sh and b_sh.
  - Latch op_l and op_s.
  - Set carry_reg = cin0 if op_l=0, otherwise 0.
  - Set bit counter = 0 and go to RUN.
- IDLE with start=0: remain in IDLE; all outputs hold.
- Cell drive in RUN: cal_a=a_sh[0], cal_b=b_sh[0], cal_c_in=carry_reg, cal_l and cal_s from the latched values. All are driven from registers, so the cell output settles within the same cycle.
- Each RUN edge:
  - result shifts right with cal_out entering at result[WIDTH-1].
  - a_sh and b_sh shift right.
  - carry_reg <= cal_c_out if arithmetic, otherwise 0.
  - Counter increments.
- After the edge that captures bit WIDTH-1: go to DONE.
- DONE lasts one cycle:
  - done=1, busy=0.
  - carry_out = carry_reg (final carry; 0 in logic mode).
  - Next state is IDLE.
- Outside RUN, the cal_* outputs are driven to 0.
- Latency: start sampled at edge N; busy=1 from N+1 through N+WIDTH; done=1 during cycle N+WIDTH+1.
- Throughput: at most one operation per WIDTH+2 cycles.
- start while in RUN or DONE is ignored and not queued. The operation in flight is unaffected.
- result is reloaded bit by bit during RUN; its value is only valid when done=1 and afterwards in IDLE.
- Arithmetic is modulo 2^WIDTH; the carry out of the MSB is reported on carry_out.
- Reset asserted mid-RUN: the next edge returns all outputs to reset values, no done pulse is issued, and the partial result is discarded.
- reset and start high in the same cycle: reset wins.

Optional Feature:
CAL_SERIAL_OVF_EN
- Defined: adds output port ovf (1 bit). At DONE, ovf = (carry into the MSB) XOR (carry out of the MSB) in arithmetic mode, giving two's-complement overflow; ovf=0 in logic mode. ovf resets to 0 and holds until the next accepted start.
- Not defined: no ovf port and no extra registers.

Test Plan:
1. WIDTH=4, op_l=0, a=0101, b=0011, cin0=0, start pulse -> busy for 4 cycles; done in 5th cycle after start; result=1000, carry_out=0, ovf=1 if enabled.
2. op_l=0, a=1111, b=0001, cin0=0 -> result=0000, carry_out=1, ovf=0. Then a=0000, b=0000, cin0=1 -> result=0001, carry_out=0.
3. op_l=1, a=1100, b=1010: s=00 -> 1000; s=01 -> 1110; s=10 -> 0110; s=11 -> 0011. carry_out=0 in every case, and cal_c_in stays 0 throughout.
4. Start accepted, then start re-asserted in RUN cycles 2 and 3 with different operands -> first result unaffected; exactly one done pulse; no second operation begins.
5. reset asserted at RUN bit 2 -> next cycle busy=0, done=0, result=0, cal_*=0; no done pulse until a new start.
6. Back-to-back: start held high continuously -> new operations accepted only in IDLE. Spacing is WIDTH+2 cycles between done pulses, and each result is correct.
